game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 33 +++
 rtl/game_ctrl_edge_det.sv | 36 +++
 rtl/game_ctrl.sv | 160 ++++++++++++++++
 tb/tb_game_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the breakout-style game controller.
//   - default parameter values (lives per game, serve hold time, level size)
//   - FSM state encoding (codes 6 and 7 are unused and recover to IDLE)
//   - saturating decrement helpers for the lives and blocks counters
// No ports; imported by game_ctrl and its testbench-visible parameters.
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int DEF_LIVES        = 10;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_NUM_BLOCKS   = 40;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LOST  = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_t;

    // Counters stop at zero instead of wrapping to all-ones.
    function automatic logic [3:0] sat_dec4(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    function automatic logic [7:0] sat_dec8(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

endpackage

// File: rtl/game_ctrl_edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
// Rising-edge detector: compares a level against its one-cycle registered copy.
// Ports:
//   clock    in  system clock
//   reset    in  synchronous active-low reset
//   i_level  in  level to watch
//   o_rise   out high for one cycle when i_level goes 0 -> 1
// The detector stays disarmed for the first cycle after reset so that a level
// already high when reset is released is not mistaken for a fresh edge.
// -----------------------------------------------------------------------------
module edge_det (
    input  logic clock,
    input  logic reset,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;
    logic r_armed;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_level;
            r_armed <= 1'b1;
        end
    end

    assign o_rise = i_level & ~r_prev & r_armed;

endmodule

// File: rtl/game_ctrl.sv
// -----------------------------------------------------------------------------
// game_ctrl
// Game flow controller: IDLE -> SERVE -> PLAY -> LOST/WIN/OVER.
// Parameters: LIVES (lives per game), SERVE_FRAMES (frames the ball is held
// before a serve), NUM_BLOCKS (blocks that clear the level).
// Ports:
//   clock, reset       in   system clock, synchronous active-low reset
//   btn_start          in   start button level
//   ball_lost          in   high while the ball is below the paddle line
//   block_hit          in   high for one or more cycles per block collision
//   frame_tick         in   one-cycle pulse per video frame
//   start              out  pulse: scoreboard clears the score
//   endgame            out  pulse: a life was lost
//   hit_block          out  pulse: add one point
//   ball_enable        out  high while in PLAY
//   serve_ball         out  pulse on PLAY entry, recentres the ball
//   state              out  encoded FSM state
//   lives, blocks_left out  remaining lives / blocks
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES        = DEF_LIVES,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int NUM_BLOCKS   = DEF_NUM_BLOCKS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       ball_lost,
    input  logic       block_hit,
    input  logic       frame_tick,
    output logic       start,
    output logic       endgame,
    output logic       hit_block,
    output logic       ball_enable,
    output logic       serve_ball,
    output logic [2:0] state,
    output logic [3:0] lives,
    output logic [7:0] blocks_left
);

    localparam logic [3:0] LIVES_INIT  = 4'(LIVES);
    localparam logic [7:0] BLOCKS_INIT = 8'(NUM_BLOCKS);
    // Counter value on the frame_tick that completes the serve hold.
    localparam logic [7:0] SERVE_LAST  = 8'(SERVE_FRAMES - 1);

    logic w_btn_rise;
    logic w_lost_rise;
    logic w_hit_rise;

    state_t     r_state;
    logic [3:0] r_lives;
    logic [7:0] r_blocks;
    logic [7:0] r_cnt;
    logic       r_start;
    logic       r_endgame;
    logic       r_hit;
    logic       r_enable;
    logic       r_serve;

    edge_det u_btn_edge  (.clock(clock), .reset(reset), .i_level(btn_start), .o_rise(w_btn_rise));
    edge_det u_lost_edge (.clock(clock), .reset(reset), .i_level(ball_lost), .o_rise(w_lost_rise));
    edge_det u_hit_edge  (.clock(clock), .reset(reset), .i_level(block_hit), .o_rise(w_hit_rise));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_lives   <= LIVES_INIT;
            r_blocks  <= BLOCKS_INIT;
            r_cnt     <= 8'd0;
            r_start   <= 1'b0;
            r_endgame <= 1'b0;
            r_hit     <= 1'b0;
            r_enable  <= 1'b0;
            r_serve   <= 1'b0;
        end else begin
            // Pulses and ball_enable default low; each branch raises only what
            // applies to the cycle after this edge, so pulses are one cycle wide.
            r_start   <= 1'b0;
            r_endgame <= 1'b0;
            r_hit     <= 1'b0;
            r_enable  <= 1'b0;
            r_serve   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_btn_rise) begin
                        r_state  <= ST_SERVE;
                        r_start  <= 1'b1;
                        r_lives  <= LIVES_INIT;
                        r_blocks <= BLOCKS_INIT;
                        r_cnt    <= 8'd0;
                    end
                end

                ST_SERVE: begin
                    if (frame_tick) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == SERVE_LAST) begin
                            r_state  <= ST_PLAY;
                            r_serve  <= 1'b1;
                            r_enable <= 1'b1;
                        end
                    end
                end

                ST_PLAY: begin
                    // A simultaneous loss outranks the hit: the hit is dropped.
                    if (w_lost_rise) begin
                        r_endgame <= 1'b1;
                        r_lives   <= sat_dec4(r_lives);
                        r_state   <= ST_LOST;
                    end else if (w_hit_rise) begin
                        r_hit    <= 1'b1;
                        r_blocks <= sat_dec8(r_blocks);
                        if (r_blocks == 8'd1) begin
                            r_state <= ST_WIN;
                        end else begin
                            r_enable <= 1'b1;
                        end
                    end else begin
                        r_enable <= 1'b1;
                    end
                end

                ST_LOST: begin
                    // Leave only once the ball is back above the line on a frame boundary.
                    if (!ball_lost && frame_tick) begin
                        if (r_lives == 4'd0) begin
                            r_state <= ST_OVER;
                        end else begin
                            r_state <= ST_SERVE;
                            r_cnt   <= 8'd0;
                        end
                    end
                end

                ST_OVER, ST_WIN: begin
                    if (w_btn_rise) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign state       = r_state;
    assign lives       = r_lives;
    assign blocks_left = r_blocks;
    assign start       = r_start;
    assign endgame     = r_endgame;
    assign hit_block   = r_hit;
    assign ball_enable = r_enable;
    assign serve_ball  = r_serve;

endmodule

// File: tb/tb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_ctrl
// Two controllers side by side: dut 0 with default parameters, dut 1 with
// LIVES=1, SERVE_FRAMES=2, NUM_BLOCKS=2. Each has its own stimulus; reset is
// shared. A game-rule model for each dut is advanced every clock and compared
// against the outputs 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_game_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] btn, lost, hit, ft;

    logic [1:0] o_start, o_endgame, o_hitb, o_en, o_serve;
    logic [2:0] o_state  [2];
    logic [3:0] o_lives  [2];
    logic [7:0] o_blocks [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    game_ctrl u_dut0 (
        .clock(clock), .reset(reset),
        .btn_start(btn[0]), .ball_lost(lost[0]), .block_hit(hit[0]), .frame_tick(ft[0]),
        .start(o_start[0]), .endgame(o_endgame[0]), .hit_block(o_hitb[0]),
        .ball_enable(o_en[0]), .serve_ball(o_serve[0]),
        .state(o_state[0]), .lives(o_lives[0]), .blocks_left(o_blocks[0])
    );

    game_ctrl #(.LIVES(1), .SERVE_FRAMES(2), .NUM_BLOCKS(2)) u_dut1 (
        .clock(clock), .reset(reset),
        .btn_start(btn[1]), .ball_lost(lost[1]), .block_hit(hit[1]), .frame_tick(ft[1]),
        .start(o_start[1]), .endgame(o_endgame[1]), .hit_block(o_hitb[1]),
        .ball_enable(o_en[1]), .serve_ball(o_serve[1]),
        .state(o_state[1]), .lives(o_lives[1]), .blocks_left(o_blocks[1])
    );

    // ---------------- game-rule model ----------------
    // st: 0 idle, 1 serving, 2 playing, 3 ball lost, 4 game over, 5 level won
    typedef struct {
        int L, SF, NB;
        int st, lives, blocks, frames;
        bit pb, pl, ph, armed;
        bit start, endg, hitp, en, serve;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t mstep(input mdl_t s, input bit rst_n,
                                   input bit b, input bit l, input bit h, input bit f);
        bit eb, el, eh;
        s.start = 0; s.endg = 0; s.hitp = 0; s.serve = 0;
        if (!rst_n) begin
            s.st = 0; s.lives = s.L; s.blocks = s.NB; s.frames = 0;
            s.pb = 0; s.pl = 0; s.ph = 0; s.armed = 0; s.en = 0;
            return s;
        end
        eb = b && !s.pb && s.armed;
        el = l && !s.pl && s.armed;
        eh = h && !s.ph && s.armed;
        s.pb = b; s.pl = l; s.ph = h; s.armed = 1;
        case (s.st)
            0: if (eb) begin
                   s.st = 1; s.start = 1; s.lives = s.L; s.blocks = s.NB; s.frames = 0;
               end
            1: if (f) begin
                   s.frames = s.frames + 1;
                   if (s.frames == s.SF) begin s.st = 2; s.serve = 1; end
               end
            2: if (el) begin
                   s.endg = 1; s.st = 3;
                   if (s.lives > 0) s.lives = s.lives - 1;
               end else if (eh) begin
                   s.hitp = 1;
                   if (s.blocks == 1) s.st = 5;
                   if (s.blocks > 0) s.blocks = s.blocks - 1;
               end
            3: if (!l && f) begin
                   if (s.lives == 0) s.st = 4;
                   else begin s.st = 1; s.frames = 0; end
               end
            4, 5: if (eb) s.st = 0;
            default: s.st = 0;
        endcase
        s.en = (s.st == 2);
        return s;
    endfunction

    function automatic logic [19:0] mexp(input mdl_t s);
        return {s.start, s.endg, s.hitp, s.en, s.serve, 3'(s.st), 4'(s.lives), 8'(s.blocks)};
    endfunction

    function automatic logic [19:0] dvec(input int i);
        return {o_start[i], o_endgame[i], o_hitb[i], o_en[i], o_serve[i],
                o_state[i], o_lives[i], o_blocks[i]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock: advance the models on the inputs present at the edge, then
    // compare every output of both duts against them.
    task automatic tick();
        for (int i = 0; i < 2; i++) m[i] = mstep(m[i], reset, btn[i], lost[i], hit[i], ft[i]);
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("model_dut%0d", i), 32'(dvec(i)), 32'(mexp(m[i])));
            check($sformatf("one_pulse_dut%0d", i),
                  32'($countones({o_start[i], o_endgame[i], o_hitb[i], o_serve[i]}) <= 1), 32'd1);
        end
    endtask

    // ---------------- dut 1 vector table ----------------
    typedef struct {
        bit b, l, h, f;
        int st;
        bit start, endg, hitp, en, serve;
        int lives, blocks;
    } vec_t;

    vec_t tbl [22];
    int   npulse;

    initial begin
        m[0].L = 10; m[0].SF = 60; m[0].NB = 40;
        m[1].L = 1;  m[1].SF = 2;  m[1].NB = 2;

        //          b l h f  st st en hi en sv lv bl
        tbl[0]  = '{0,0,0,0, 0, 0, 0, 0, 0, 0, 1, 2};
        tbl[1]  = '{1,0,0,0, 1, 1, 0, 0, 0, 0, 1, 2};  // start edge
        tbl[2]  = '{1,0,0,1, 1, 0, 0, 0, 0, 0, 1, 2};  // held start, frame 1
        tbl[3]  = '{0,0,0,1, 2, 0, 0, 0, 1, 1, 1, 2};  // frame 2 -> serve
        tbl[4]  = '{0,0,1,0, 2, 0, 0, 1, 1, 0, 1, 1};  // hit
        tbl[5]  = '{0,0,1,0, 2, 0, 0, 0, 1, 0, 1, 1};  // hit held: no pulse
        tbl[6]  = '{0,0,0,0, 2, 0, 0, 0, 1, 0, 1, 1};
        tbl[7]  = '{0,0,1,0, 5, 0, 0, 1, 0, 0, 1, 0};  // last block -> win
        tbl[8]  = '{0,0,0,0, 5, 0, 0, 0, 0, 0, 1, 0};
        tbl[9]  = '{0,0,1,0, 5, 0, 0, 0, 0, 0, 1, 0};  // hit ignored in win
        tbl[10] = '{0,1,0,0, 5, 0, 0, 0, 0, 0, 1, 0};  // loss ignored in win
        tbl[11] = '{1,0,0,0, 0, 0, 0, 0, 0, 0, 1, 0};  // start -> idle, no pulse
        tbl[12] = '{0,0,0,0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[13] = '{1,0,0,0, 1, 1, 0, 0, 0, 0, 1, 2};  // new game
        tbl[14] = '{0,0,0,1, 1, 0, 0, 0, 0, 0, 1, 2};
        tbl[15] = '{0,0,0,1, 2, 0, 0, 0, 1, 1, 1, 2};
        tbl[16] = '{0,1,1,0, 3, 0, 1, 0, 0, 0, 0, 2};  // loss beats hit
        tbl[17] = '{0,1,0,1, 3, 0, 0, 0, 0, 0, 0, 2};  // ball still low
        tbl[18] = '{0,0,0,0, 3, 0, 0, 0, 0, 0, 0, 2};
        tbl[19] = '{0,0,0,1, 4, 0, 0, 0, 0, 0, 0, 2};  // no lives -> over
        tbl[20] = '{0,0,0,1, 4, 0, 0, 0, 0, 0, 0, 2};
        tbl[21] = '{1,0,0,0, 0, 0, 0, 0, 0, 0, 0, 2};  // start -> idle

        // ---------------- reset ----------------
        reset = 1'b0; btn = '0; lost = '0; hit = '0; ft = '0;
        tick(); tick();
        check("rst_state",  32'(o_state[0]),  32'd0);
        check("rst_lives",  32'(o_lives[0]), 32'd10);
        check("rst_blocks", 32'(o_blocks[0]), 32'd40);
        check("rst_outs",   32'({o_start[0], o_endgame[0], o_hitb[0], o_en[0], o_serve[0]}), 32'd0);
        reset = 1'b1;
        tick();

        // ---------------- start and serve (defaults) ----------------
        btn[0] = 1'b1; tick();
        check("start_pulse", 32'(o_start[0]), 32'd1);
        check("start_state", 32'(o_state[0]), 32'd1);
        btn[0] = 1'b0; tick();
        check("start_width", 32'(o_start[0]), 32'd0);
        for (int i = 0; i < 60; i++) begin
            ft[0] = 1'b1; tick(); ft[0] = 1'b0;
            if (i < 59) begin
                check("serve_hold", 32'(o_state[0]), 32'd1);
            end else begin
                check("play_state",  32'(o_state[0]), 32'd2);
                check("serve_pulse", 32'(o_serve[0]), 32'd1);
                check("play_enable", 32'(o_en[0]),    32'd1);
            end
            tick();
        end
        check("serve_width", 32'(o_serve[0]), 32'd0);
        check("enable_held", 32'(o_en[0]),    32'd1);

        // ---------------- held hit gives one point ----------------
        npulse = 0;
        hit[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); npulse += int'(o_hitb[0]); end
        hit[0] = 1'b0; tick(); npulse += int'(o_hitb[0]);
        check("hit_count",  32'(npulse),       32'd1);
        check("hit_blocks", 32'(o_blocks[0]), 32'd39);

        // ---------------- loss and hit together ----------------
        lost[0] = 1'b1; hit[0] = 1'b1; tick();
        check("both_endgame", 32'(o_endgame[0]), 32'd1);
        check("both_nohit",   32'(o_hitb[0]),    32'd0);
        check("both_blocks",  32'(o_blocks[0]),  32'd39);
        check("both_lives",   32'(o_lives[0]),   32'd9);
        check("both_state",   32'(o_state[0]),   32'd3);
        lost[0] = 1'b0; hit[0] = 1'b0;
        ft[0] = 1'b1; tick(); ft[0] = 1'b0;
        check("reserve_state", 32'(o_state[0]), 32'd1);

        // ---------------- reset mid-serve with start held ----------------
        btn[0] = 1'b1; reset = 1'b0; tick();
        check("midrst_state", 32'(o_state[0]), 32'd0);
        check("midrst_lives", 32'(o_lives[0]), 32'd10);
        tick();
        reset = 1'b1; tick();
        check("release_nostart", 32'(o_start[0]), 32'd0);
        tick(); tick();
        check("held_nostart", 32'(o_start[0]), 32'd0);
        check("held_idle",    32'(o_state[0]), 32'd0);
        btn[0] = 1'b0; tick();
        btn[0] = 1'b1; tick();
        check("fresh_start",  32'(o_start[0]), 32'd1);
        check("fresh_state",  32'(o_state[0]), 32'd1);
        btn[0] = 1'b0; tick();

        // ---------------- dut 1 table ----------------
        for (int k = 0; k < 22; k++) begin
            btn[1] = tbl[k].b; lost[1] = tbl[k].l; hit[1] = tbl[k].h; ft[1] = tbl[k].f;
            tick();
            check($sformatf("vec%0d", k), 32'(dvec(1)),
                  32'({tbl[k].start, tbl[k].endg, tbl[k].hitp, tbl[k].en, tbl[k].serve,
                       3'(tbl[k].st), 4'(tbl[k].lives), 8'(tbl[k].blocks)}));
        end
        btn = '0; lost = '0; hit = '0; ft = '0;
        tick();

        // ---------------- randomized play against the model ----------------
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 9)  == 0) btn[i]  = ~btn[i];
                if ($urandom_range(0, 24) == 0) lost[i] = ~lost[i];
                if ($urandom_range(0, 3)  == 0) hit[i]  = ~hit[i];
                ft[i] = ($urandom_range(0, 3) == 0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
